// File: rtl/fetch_pkg.sv
// Shared constants for the fetch sequencer: opcodes, FSM state encoding, default widths.
package fetch_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_NOA = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH_HI = 3'd1,
    ST_FETCH_LO = 3'd2,
    ST_OPERAND  = 3'd3,
    ST_ISSUE    = 3'd4,
    ST_HALTED   = 3'd5
  } state_t;

  function automatic logic is_operand_read(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/op_decode.sv
// Opcode classification for the fetch sequencer.
module op_decode
  import fetch_pkg::*;
(
  input  logic [2:0] op,
  output logic       readOperand,
  output logic       store,
  output logic       jump,
  output logic       condJump,
  output logic       issueOnly,
  output logic       halt
);

  assign readOperand = is_operand_read(op);
  assign store       = (op == OP_STA);
  assign jump        = (op == OP_JMP);
  assign condJump    = (op == OP_JZ);
  assign issueOnly   = (op == OP_NOA);
  assign halt        = (op == OP_HLT);

endmodule

// File: rtl/fetch_sequencer.sv
// Memory-port initiator: fetches two-byte instructions, performs operand read/store,
// and hands decoded instructions to the accumulator datapath via valid/ready.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no memory access, waiting for start
// ST_FETCH_HI | read byte0 {opcode, target hi} at pc
// ST_FETCH_LO | read byte1 target lo at pc, resolve jumps / next step
// ST_OPERAND  | operand read (ADD/AND/LDA) or store of accIn (STA) at target
// ST_ISSUE    | instValid held until instReady
// ST_HALTED   | HLT executed, only reset exits
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] addressMem,
  output logic [DATA_W-1:0] dataMem,
  input  logic [DATA_W-1:0] memOut,
  input  logic [DATA_W-1:0] accIn,
  input  logic              zeroIn,
  output logic              instValid,
  input  logic              instReady,
  output logic [2:0]        instOp,
  output logic [DATA_W-1:0] instData,
  output logic [ADDR_W-1:0] pcOut,
  output logic              halted
);

  localparam int TGT_HI_W = ADDR_W - DATA_W;

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcInc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] fetchTarget;
  logic [DATA_W-1:0] irHi;
  logic [2:0]        curOp;
  logic              readOperand;
  logic              store;
  logic              jump;
  logic              condJump;
  logic              issueOnly;
  logic              halt;
  logic              takeJump;

  // irHi is only loaded in FETCH_HI, so it still names the current op during OPERAND
  assign curOp       = irHi[DATA_W-1 -: 3];
  assign fetchTarget = {irHi[TGT_HI_W-1:0], memOut};
  assign pcInc       = pc + ADDR_W'(1);
  assign takeJump    = jump | (condJump & zeroIn);
  assign pcOut       = pc;

  op_decode u_op_decode (
    .op          (curOp),
    .readOperand (readOperand),
    .store       (store),
    .jump        (jump),
    .condJump    (condJump),
    .issueOnly   (issueOnly),
    .halt        (halt)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:     if (start) stateNext = ST_FETCH_HI;
      ST_FETCH_HI: stateNext = ST_FETCH_LO;
      ST_FETCH_LO: begin
        if (readOperand || store) stateNext = ST_OPERAND;
        else if (issueOnly)       stateNext = ST_ISSUE;
        else if (halt)            stateNext = ST_HALTED;
        else                      stateNext = ST_FETCH_HI;
      end
      ST_OPERAND:  stateNext = store ? ST_FETCH_HI : ST_ISSUE;
      ST_ISSUE:    if (instReady) stateNext = ST_FETCH_HI;
      ST_HALTED:   stateNext = ST_HALTED;
      default:     stateNext = ST_IDLE;
    endcase
  end

  // Enables are gated by rst_n so a reset cycle can never write memory
  always_comb begin
    memRead    = 1'b0;
    memWrite   = 1'b0;
    addressMem = '0;
    dataMem    = '0;
    instValid  = 1'b0;
    halted     = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH_HI, ST_FETCH_LO: begin
          memRead    = 1'b1;
          addressMem = pc;
        end
        ST_OPERAND: begin
          addressMem = target;
          if (store) begin
            memWrite = 1'b1;
            dataMem  = accIn;
          end else begin
            memRead = 1'b1;
          end
        end
        ST_ISSUE:  instValid = 1'b1;
        ST_HALTED: halted    = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      irHi     <= '0;
      target   <= '0;
      instOp   <= '0;
      instData <= '0;
    end else begin
      case (state)
        ST_FETCH_HI: begin
          irHi <= memOut;
          pc   <= pcInc;
        end
        ST_FETCH_LO: begin
          pc     <= takeJump ? fetchTarget : pcInc;
          instOp <= curOp;
          target <= fetchTarget;
          if (!readOperand) instData <= '0;
        end
        ST_OPERAND: begin
          if (readOperand) instData <= memOut;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational-read memory model.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        start;
  logic        memRead;
  logic        memWrite;
  logic [12:0] addressMem;
  logic [7:0]  dataMem;
  logic [7:0]  memOut;
  logic [7:0]  accIn;
  logic        zeroIn;
  logic        instValid;
  logic        instReady;
  logic [2:0]  instOp;
  logic [7:0]  instData;
  logic [12:0] pcOut;
  logic        halted;

  logic [7:0]  mem [0:8191];
  int          errors = 0;
  int          checks = 0;

  fetch_sequencer dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .addressMem (addressMem),
    .dataMem    (dataMem),
    .memOut     (memOut),
    .accIn      (accIn),
    .zeroIn     (zeroIn),
    .instValid  (instValid),
    .instReady  (instReady),
    .instOp     (instOp),
    .instData   (instData),
    .pcOut      (pcOut),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  assign memOut = memRead ? mem[addressMem] : 8'h00;

  // Memory writes are applied here with pre-edge values so one process owns mem
  task automatic tick();
    @(posedge clock);
    if (memWrite) mem[addressMem] = dataMem;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; instReady = 1'b1; accIn = 8'h00; zeroIn = 1'b0;
    clear_mem();
    #1;
    chk("rst_comb_memRead",  32'(memRead), 0);
    chk("rst_comb_memWrite", 32'(memWrite), 0);
    tick();
    rst_n = 1'b1;
    chk("rst_pc",        32'(pcOut), 0);
    chk("rst_instValid", 32'(instValid), 0);
    chk("rst_instOp",    32'(instOp), 0);
    chk("rst_instData",  32'(instData), 0);
    chk("rst_addr",      32'(addressMem), 0);
    chk("rst_halted",    32'(halted), 0);
    tick();
    chk("idle_no_read",  32'(memRead), 0);

    // LDA 0x010
    mem[0] = 8'h40; mem[1] = 8'h10; mem[16] = 8'h07;
    do_reset(); go();
    chk("lda_fh_read", 32'(memRead), 1);
    chk("lda_fh_addr", 32'(addressMem), 'h000);
    tick();
    chk("lda_fl_read", 32'(memRead), 1);
    chk("lda_fl_addr", 32'(addressMem), 'h001);
    tick();
    chk("lda_op_read", 32'(memRead), 1);
    chk("lda_op_addr", 32'(addressMem), 'h010);
    tick();
    chk("lda_valid",   32'(instValid), 1);
    chk("lda_op",      32'(instOp), 2);
    chk("lda_data",    32'(instData), 'h07);
    chk("lda_pc",      32'(pcOut), 2);
    chk("lda_iss_rd",  32'(memRead), 0);
    tick();
    chk("lda_drop",    32'(instValid), 0);
    chk("lda_next_pc", 32'(addressMem), 'h002);

    // STA 0x020
    clear_mem();
    mem[0] = 8'h60; mem[1] = 8'h20; accIn = 8'hA5;
    do_reset(); go(); tick(); tick();
    chk("sta_we",      32'(memWrite), 1);
    chk("sta_rd",      32'(memRead), 0);
    chk("sta_addr",    32'(addressMem), 'h020);
    chk("sta_data",    32'(dataMem), 'hA5);
    chk("sta_valid",   32'(instValid), 0);
    tick();
    chk("sta_we_once", 32'(memWrite), 0);
    chk("sta_mem",     32'(mem[32]), 'hA5);
    chk("sta_next",    32'(addressMem), 'h002);
    chk("sta_valid2",  32'(instValid), 0);

    // JZ 0x100 taken / not taken
    clear_mem();
    mem[0] = 8'hA1; mem[1] = 8'h00; zeroIn = 1'b1;
    do_reset(); go(); tick(); tick();
    chk("jz_taken_addr", 32'(addressMem), 'h100);
    chk("jz_taken_rd",   32'(memRead), 1);
    zeroIn = 1'b0;
    do_reset(); go(); tick(); tick();
    chk("jz_not_addr",   32'(addressMem), 'h002);

    // ADD with operand 0x33, datapath stalls
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'h30; mem[48] = 8'h33; instReady = 1'b0;
    do_reset(); go(); tick(); tick(); tick();
    for (int i = 0; i < 6; i++) begin
      chk("stall_valid", 32'(instValid), 1);
      chk("stall_op",    32'(instOp), 0);
      chk("stall_data",  32'(instData), 'h33);
      chk("stall_noacc", 32'({memRead, memWrite}), 0);
      if (i < 5) tick();
    end
    instReady = 1'b1;
    tick();
    chk("stall_drop",   32'(instValid), 0);
    chk("stall_resume", 32'(memRead), 1);
    chk("stall_addr",   32'(addressMem), 'h002);

    // HLT ignores start
    clear_mem();
    mem[0] = 8'hE0;
    do_reset(); go(); tick(); tick();
    chk("hlt_halted", 32'(halted), 1);
    chk("hlt_noread", 32'(memRead), 0);
    go(); tick();
    chk("hlt_stays",  32'(halted), 1);
    chk("hlt_pc",     32'(pcOut), 2);

    // Reset during STA operand cycle
    clear_mem();
    mem[0] = 8'h60; mem[1] = 8'h20; accIn = 8'h5A;
    do_reset();
    chk("hlt_exit", 32'(halted), 0);
    go(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rstop_we",   32'(memWrite), 0);
    chk("rstop_addr", 32'(addressMem), 0);
    tick();
    rst_n = 1'b1;
    chk("rstop_mem",   32'(mem[32]), 0);
    chk("rstop_pc",    32'(pcOut), 0);
    chk("rstop_op",    32'(instOp), 0);
    chk("rstop_data",  32'(instData), 0);
    chk("rstop_valid", 32'(instValid), 0);
    tick();
    chk("rstop_idle",  32'({memRead, memWrite, halted}), 0);

    // PC wrap: ADD, then JMP 0x1FFF, NOA at 8191 with byte1 from address 0
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'h05; mem[5] = 8'h11;
    mem[2] = 8'h9F; mem[3] = 8'hFF; mem[8191] = 8'hC0;
    do_reset(); go(); tick(); tick(); tick();
    chk("wrap_add_data", 32'(instData), 'h11);
    tick(); tick(); tick();
    chk("wrap_jmp_addr", 32'(addressMem), 'h1FFF);
    tick();
    chk("wrap_lo_addr",  32'(addressMem), 'h000);
    chk("wrap_lo_pc",    32'(pcOut), 0);
    tick();
    chk("wrap_valid",    32'(instValid), 1);
    chk("wrap_op",       32'(instOp), 6);
    chk("wrap_data",     32'(instData), 0);
    chk("wrap_pc",       32'(pcOut), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
